// File: rtl/fmul_pipe.sv
// fmul_pipe: three-stage pipelined floating-point multiplier with valid/ready on
// both sides, round-to-nearest-even (or truncation), NaN/inf/zero handling and
// overflow/underflow flags. Denormal operands are flushed to zero and no denormal
// results are produced.
//
// Ports:
//   clk        clock, all flops rise-edge
//   rstn       asynchronous active-low reset
//   in_valid   operands x1/x2 valid
//   in_ready   block accepts operands this cycle (combinational from out_ready)
//   x1, x2     operands {sign, exp, frac}
//   out_valid  y and flags valid
//   out_ready  consumer accepts result this cycle
//   y          product
//   ovf        finite inputs overflowed to infinity
//   unf        non-zero result flushed to zero
//   nan        result is the canonical NaN
//
// Requires FRAC_W >= 2.
module fmul_pipe #(
  parameter int unsigned EXP_W    = 8,
  parameter int unsigned FRAC_W   = 23,
  parameter bit          ROUND_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+FRAC_W:0] x1,
  input  logic [EXP_W+FRAC_W:0] x2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] y,
  output logic                  ovf,
  output logic                  unf,
  output logic                  nan
);

  localparam int unsigned W    = 1 + EXP_W + FRAC_W;
  localparam int unsigned MW   = FRAC_W + 1;          // mantissa incl. hidden bit
  localparam int unsigned PW   = 2 * MW;              // full product width
  localparam int unsigned EW   = EXP_W + 2;           // signed exponent, no wrap
  localparam int unsigned HL   = MW / 2;              // low slice of operand B
  localparam int unsigned HH   = MW - HL;             // high slice of operand B
  localparam int unsigned BIAS = (2 ** (EXP_W - 1)) - 1;
  localparam int unsigned EMAX = (2 ** EXP_W) - 1;

  localparam logic [FRAC_W-1:0] QNAN_FRAC = FRAC_W'(1) << (FRAC_W - 1);

  // Pipeline control: a stage loads when empty or when its contents move on.
  logic v1, v2, ld1, ld2, ld3;

  always_comb begin
    ld3      = ~out_valid | out_ready;
    ld2      = ~v2 | ld3;
    ld1      = ~v1 | ld2;
    in_ready = ld1;
  end

  // ---------------- S1: unpack, classify, partial products ----------------
  logic              sgn_a, sgn_b;
  logic [EXP_W-1:0]  exp_a, exp_b;
  logic [FRAC_W-1:0] frac_a, frac_b;
  logic              zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic [MW-1:0]     man_a, man_b;
  logic [MW+HL-1:0]  pp_lo_c;
  logic [MW+HH-1:0]  pp_hi_c;
  logic [EW-1:0]     exp_sum_c;

  always_comb begin
    {sgn_a, exp_a, frac_a} = x1;
    {sgn_b, exp_b, frac_b} = x2;
    zero_a    = (exp_a == '0);
    zero_b    = (exp_b == '0);
    inf_a     = (&exp_a) && (frac_a == '0);
    inf_b     = (&exp_b) && (frac_b == '0);
    nan_a     = (&exp_a) && (frac_a != '0);
    nan_b     = (&exp_b) && (frac_b != '0);
    man_a     = {1'b1, frac_a};
    man_b     = {1'b1, frac_b};
    pp_lo_c   = (MW+HL)'(man_a) * (MW+HL)'(man_b[HL-1:0]);
    pp_hi_c   = (MW+HH)'(man_a) * (MW+HH)'(man_b[MW-1:HL]);
    exp_sum_c = EW'(exp_a) + EW'(exp_b) - EW'(BIAS);
  end

  logic              s1_sign, s1_nan, s1_inf, s1_zero;
  logic [EW-1:0]     s1_exp;
  logic [MW+HL-1:0]  s1_pp_lo;
  logic [MW+HH-1:0]  s1_pp_hi;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1       <= 1'b0;
      s1_sign  <= 1'b0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_zero  <= 1'b0;
      s1_exp   <= '0;
      s1_pp_lo <= '0;
      s1_pp_hi <= '0;
    end else if (ld1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_sign  <= sgn_a ^ sgn_b;
        // NaN operand or 0*inf both yield the canonical NaN
        s1_nan   <= nan_a | nan_b | (zero_a & inf_b) | (inf_a & zero_b);
        s1_inf   <= inf_a | inf_b;
        s1_zero  <= zero_a | zero_b;
        s1_exp   <= exp_sum_c;
        s1_pp_lo <= pp_lo_c;
        s1_pp_hi <= pp_hi_c;
      end
    end
  end

  // ---------------- S2: sum partial products, normalise ----------------
  logic [PW-1:0]     prod_c;
  logic [FRAC_W-1:0] frac_n_c;
  logic              guard_c, sticky_c;
  logic [EW-1:0]     exp_n_c;

  always_comb begin
    prod_c  = (PW'(s1_pp_hi) << HL) + PW'(s1_pp_lo);
    exp_n_c = s1_exp + EW'(prod_c[PW-1]);
    // Product of two [1,2) mantissas lies in [1,4); MSB set means value >= 2.
    if (prod_c[PW-1]) begin
      frac_n_c = prod_c[PW-2 -: FRAC_W];
      guard_c  = prod_c[FRAC_W];
      sticky_c = |prod_c[FRAC_W-1:0];
    end else begin
      frac_n_c = prod_c[PW-3 -: FRAC_W];
      guard_c  = prod_c[FRAC_W-1];
      sticky_c = |prod_c[FRAC_W-2:0];
    end
  end

  logic              s2_sign, s2_nan, s2_inf, s2_zero;
  logic [EW-1:0]     s2_exp;
  logic [FRAC_W-1:0] s2_frac;
  logic              s2_guard, s2_sticky;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2        <= 1'b0;
      s2_sign   <= 1'b0;
      s2_nan    <= 1'b0;
      s2_inf    <= 1'b0;
      s2_zero   <= 1'b0;
      s2_exp    <= '0;
      s2_frac   <= '0;
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        s2_sign   <= s1_sign;
        s2_nan    <= s1_nan;
        s2_inf    <= s1_inf;
        s2_zero   <= s1_zero;
        s2_exp    <= exp_n_c;
        s2_frac   <= frac_n_c;
        s2_guard  <= guard_c;
        s2_sticky <= sticky_c;
      end
    end
  end

  // ---------------- S3: round, range check, pack ----------------
  logic              inc_c, carry_c;
  logic [FRAC_W-1:0] frac_r_c;
  logic [EW-1:0]     exp_r_c;
  logic [W-1:0]      y_c;
  logic              ovf_c, unf_c, nan_c;

  always_comb begin
    inc_c = ROUND_EN && s2_guard && (s2_sticky || s2_frac[0]);
    // Carry out of the fraction means the mantissa rounded up to 2.0:
    // the fraction wraps to zero and the exponent steps up.
    {carry_c, frac_r_c} = (FRAC_W+1)'(s2_frac) + (FRAC_W+1)'(inc_c);
    exp_r_c = s2_exp + EW'(carry_c);
    y_c     = {s2_sign, exp_r_c[EXP_W-1:0], frac_r_c};
    ovf_c   = 1'b0;
    unf_c   = 1'b0;
    nan_c   = 1'b0;
    if (s2_nan) begin
      y_c   = {1'b0, {EXP_W{1'b1}}, QNAN_FRAC};
      nan_c = 1'b1;
    end else if (s2_inf) begin
      y_c = {s2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (s2_zero) begin
      y_c = {s2_sign, {(W-1){1'b0}}};
    end else if (!exp_r_c[EW-1] && (exp_r_c >= EW'(EMAX))) begin
      y_c   = {s2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      ovf_c = 1'b1;
    end else if (exp_r_c[EW-1] || (exp_r_c == '0)) begin
      y_c   = {s2_sign, {(W-1){1'b0}}};
      unf_c = 1'b1;
    end
  end

  // Output registers hold steady while the consumer stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      y         <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      nan       <= 1'b0;
    end else if (ld3) begin
      out_valid <= v2;
      if (v2) begin
        y   <= y_c;
        ovf <= ovf_c;
        unf <= unf_c;
        nan <= nan_c;
      end
    end
  end

endmodule
